// File: rtl/mux_nx1_stream_if.sv
// Stream bundle for the N-to-1 mux: N producer channels in, one registered beat out.
// The master side drives channel data and consumer ready; the slave side is the mux.
interface mux_nx1_stream_if #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2
);
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N-1:0][W-1:0]   in_data;
    logic [N-1:0]          in_valid;
    logic [N-1:0]          in_ready;
    logic [W-1:0]          out_data;
    logic [SEL_W-1:0]      out_chan;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_nx1_stream.sv
// N-to-1 streaming mux with fixed-select or round-robin grant and a one-entry
// registered output stage; per-channel ready/data gating lives in mux_nx1_lane.
module mux_nx1_lane #(
    parameter int W     = 8,
    parameter int SEL_W = 2,
    parameter int LANE  = 0
) (
    input  logic             load,
    input  logic             gnt_ok,
    input  logic [SEL_W-1:0] gnt,
    input  logic [W-1:0]     data,
    output logic             ready,
    output logic [W-1:0]     data_m
);
    logic hit;

    assign hit    = gnt_ok && (gnt == SEL_W'(LANE));
    assign ready  = load && hit;
    assign data_m = hit ? data : '0;
endmodule

module mux_nx1_stream #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_nx1_stream_if.slave    bus
);
    localparam int IW = SEL_W + 1;

    logic                load;
    logic                gnt_ok;
    logic                fx_ok;
    logic                rr_ok;
    logic [SEL_W-1:0]    gnt;
    logic [SEL_W-1:0]    rr_gnt;
    logic [SEL_W-1:0]    ptr;
    logic [IW-1:0]       rr_idx;
    logic [N-1:0][W-1:0] data_m;
    logic [W-1:0]        sel_data;

    logic                out_valid_q;
    logic [W-1:0]        out_data_q;
    logic [SEL_W-1:0]    out_chan_q;

    // Gated by rst_n so no channel sees ready while reset is held.
    assign load = rst_n && (!out_valid_q || bus.out_ready);

    // Compare against each legal index so an out-of-range sel simply never matches.
    always_comb begin
        fx_ok = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.sel == SEL_W'(i)) fx_ok = bus.in_valid[i];
        end
    end

    // Walk ptr, ptr+1, ... wrapping at N; first valid channel wins.
    always_comb begin
        rr_ok  = 1'b0;
        rr_gnt = '0;
        rr_idx = '0;
        for (int k = 0; k < N; k++) begin
            rr_idx = {1'b0, ptr} + IW'(k);
            if (rr_idx >= IW'(N)) rr_idx = rr_idx - IW'(N);
            for (int i = 0; i < N; i++) begin
                if (!rr_ok && (rr_idx == IW'(i)) && bus.in_valid[i]) begin
                    rr_ok  = 1'b1;
                    rr_gnt = SEL_W'(i);
                end
            end
        end
    end

    assign gnt    = bus.mode ? rr_gnt : bus.sel;
    assign gnt_ok = bus.mode ? rr_ok  : fx_ok;

    for (genvar i = 0; i < N; i++) begin : g_lane
        mux_nx1_lane #(
            .W     (W),
            .SEL_W (SEL_W),
            .LANE  (i)
        ) u_lane (
            .load   (load),
            .gnt_ok (gnt_ok),
            .gnt    (gnt),
            .data   (bus.in_data[i]),
            .ready  (bus.in_ready[i]),
            .data_m (data_m[i])
        );
    end

    // At most one lane passes data, so an OR-reduce is the mux.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) sel_data = sel_data | data_m[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr         <= '0;
        end else if (load) begin
            out_valid_q <= gnt_ok;
            if (gnt_ok) begin
                out_data_q <= sel_data;
                out_chan_q <= gnt;
                if (bus.mode) ptr <= (gnt == SEL_W'(N - 1)) ? '0 : gnt + SEL_W'(1);
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
endmodule

// File: doc/mux_nx1_stream.md
Name: mux_nx1_stream

Overview:
Parametrised N-to-1 streaming multiplexer, the next generation of the team's 2:1 combinational mux. Each of the N input channels carries data with a valid/ready handshake. The block runs in one of two modes: fixed-select, where an external select chooses the channel, or round-robin arbitration. The selected beat lands in a one-entry registered output stage with its own valid/ready handshake. It sits between multiple producers and a single shared consumer.

Parameters:
N, 4, number of input channels (2..16).
W, 8, data width per channel in bits.
SEL_W, 2, width of select and channel-index fields; 2**SEL_W >= N is required.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
mode  input  1  0 = fixed-select, 1 = round-robin.
sel  input  SEL_W  channel index, used in fixed-select mode only.
in_data  input  N*W  channel i occupies bits [i*W +: W].
in_valid  input  N  per-channel valid.
in_ready  output  N  per-channel ready; combinational.
out_data  output  W  registered output data.
out_chan  output  SEL_W  index of the channel that supplied out_data.
out_valid  output  1  output register holds a beat.
out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0. in_ready=0 while reset is asserted.
- load = !out_valid || out_ready. The output register can take a new beat when it is empty or is draining in the same cycle.
- Grant, fixed-select mode (mode=0):
  - gnt_ok = (sel < N) && in_valid[sel]; gnt = sel.
  - sel >= N gives no grant; all in_ready=0.
- Grant, round-robin mode (mode=1):
  - Search channels ptr, ptr+1, … N-1, 0, … ptr-1, in that order.
  - gnt = first index with in_valid set; gnt_ok = any in_valid.
- in_ready[i] = load && gnt_ok && (gnt == i). At most one in_ready is high per cycle. in_ready never depends on in_valid of the same channel beyond the grant search.
- Transfer occurs on in_valid[gnt] && in_ready[gnt]. At the next clock edge:
  - out_data <= channel gnt data.
  - out_chan <= gnt.
  - out_valid <= 1.
- Round-robin pointer update:
  - In mode=1, ptr <= (gnt == N-1) ? 0 : gnt+1.
  - In mode=0, ptr is unchanged.
- load && !gnt_ok: out_valid <= 0 (the drained beat is not replaced). out_data and out_chan hold their last values.
- !load (out_valid && !out_ready): out_data, out_chan and out_valid are held stable; all in_ready=0.
- Timing:
  - Latency is 1 cycle from input transfer to out_valid.
  - Sustained throughput is 1 beat/cycle when out_ready is held high.
- Simultaneous drain and fill in the same cycle:
  - The new beat replaces the old one.
  - out_valid stays 1.
  - No bubble is inserted.
- Changing mode or sel mid-stream:
  - The change takes effect at the next grant decision.
  - The beat already held in the output register is unaffected.
  - ptr is preserved across mode changes.
- Fairness in round-robin mode: with all N channels continuously valid and out_ready=1, each channel is granted exactly once in every N consecutive transfers.
- Reset asserted mid-operation: a held beat is discarded (out_valid=0 immediately). After rst_n deasserts, operation restarts from ptr=0.
- No X-propagation: an unused sel value yields no grant and no state change.

Test Plan:
1. Fixed-select, N=4, W=8, mode=0, sel=2, in_valid=4'b0110, ch1=0x11, ch2=0xA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=0xA5, out_chan=2.
2. Round-robin, all valid, ch i data = 0x10+i, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3; out_data 0x10,0x11,0x12,0x13 repeating; no idle cycles.
3. Backpressure: beat 0x33 held, out_ready=0 for 3 cycles -> out_data=0x33 and out_valid=1 stable, in_ready=0; out_ready=1 -> next beat loads same cycle, out_valid stays 1.
4. Sparse round-robin: ptr=1, in_valid=4'b1001 -> grant ch3, ptr becomes 0; next cycle with in_valid=4'b1001 -> grant ch0.
5. Fixed-select with N=3, SEL_W=2, sel=3 -> in_ready=0, out_valid falls to 0 after draining, no state change.
6. Reset mid-operation: out_valid=1 with out_data=0x5A, rst_n pulsed low between clock edges -> out_valid=0, out_data=0 without a clock edge; after release, round-robin with all valid grants ch0 first.
